// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encoding and FSM state encoding for the iterative ALU
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_DIV = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MUL_RUN = 2'd1;
  localparam logic [1:0] ST_DIV_RUN = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/alu_iter_core.sv
// rtl/alu_iter_core.sv - shared shift-add multiply / restoring divide datapath, WIDTH iterations
module alu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             run;
  logic             div_mode;
  logic             neg_res;
  logic             b_zero;
  logic [CW-1:0]    cnt;
  // acc: product accumulator or partial remainder; opa: multiplicand or dividend/quotient; opb: multiplier or divisor
  logic [WIDTH-1:0] acc, opa, opb;
  logic [WIDTH-1:0] acc_nxt, opa_nxt, opb_nxt, mag;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;

  assign a_abs = a[WIDTH-1] ? -a : a;
  assign b_abs = b[WIDTH-1] ? -b : b;

  always_comb begin
    rem_sh  = {acc, opa[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, opb});
    acc_nxt = acc;
    opa_nxt = opa;
    opb_nxt = opb;
    if (div_mode) begin
      acc_nxt = rem_ge ? WIDTH'(rem_sh - {1'b0, opb}) : rem_sh[WIDTH-1:0];
      opa_nxt = {opa[WIDTH-2:0], rem_ge};
    end else begin
      acc_nxt = opb[0] ? acc + opa : acc;
      opa_nxt = opa << 1;
      opb_nxt = opb >> 1;
    end
    // Result reflects the final iteration so the top can capture it on the done cycle.
    mag    = div_mode ? opa_nxt : acc_nxt;
    result = (div_mode && b_zero) ? '1 : (neg_res ? -mag : mag);
    done   = run && (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      div_mode <= 1'b0;
      neg_res  <= 1'b0;
      b_zero   <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      opa      <= '0;
      opb      <= '0;
    end else if (flush) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run      <= 1'b1;
      cnt      <= '0;
      div_mode <= is_div;
      neg_res  <= a[WIDTH-1] ^ b[WIDTH-1];
      b_zero   <= (b == '0);
      acc      <= '0;
      opa      <= a_abs;
      opb      <= b_abs;
    end else if (run) begin
      acc <= acc_nxt;
      opa <= opa_nxt;
      opb <= opb_nxt;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_iterative.sv
// rtl/alu_iterative.sv - multicycle ALU with valid/ready handshake, flush, iterative MUL/DIV
module alu_iterative
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [OPW-1:0]   ALUCtrl_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o,
  output logic             ovf_o,
  output logic             busy_o
);

  logic [1:0]       state;
  logic [2:0]       op_in;
  logic             accept, iter_start, core_done;
  logic [WIDTH-1:0] core_result, single_res, sum, diff;
  logic             single_ovf;
  logic [WIDTH-1:0] data_r;
  logic             zero_r, ovf_r;

  assign op_in       = ALUCtrl_i[2:0];
  assign in_ready_o  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready_i);
  assign accept      = in_valid_i && in_ready_o && !flush_i;
  assign iter_start  = accept && is_iter_op(op_in);
  assign out_valid_o = (state == ST_DONE);
  assign busy_o      = (state == ST_MUL_RUN) || (state == ST_DIV_RUN);
  assign data_o      = data_r;
  assign Zero_o      = zero_r;
  assign ovf_o       = ovf_r;

  assign sum  = data1_i + data2_i;
  assign diff = data1_i - data2_i;

  always_comb begin
    single_res = '0;
    single_ovf = 1'b0;
    case (op_in)
      ALU_AND: single_res = data1_i & data2_i;
      ALU_OR:  single_res = data1_i | data2_i;
      ALU_XOR: single_res = data1_i ^ data2_i;
      ALU_ADD: begin
        single_res = sum;
        single_ovf = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) && (sum[WIDTH-1] != data1_i[WIDTH-1]);
      end
      ALU_SUB: begin
        single_res = diff;
        single_ovf = (data1_i[WIDTH-1] != data2_i[WIDTH-1]) && (diff[WIDTH-1] != data1_i[WIDTH-1]);
      end
      ALU_SLT: single_res = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
      default: single_res = '0;
    endcase
  end

  alu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .flush  (flush_i),
    .start  (iter_start),
    .is_div (op_in == ALU_DIV),
    .a      (data1_i),
    .b      (data2_i),
    .done   (core_done),
    .result (core_result)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= ST_IDLE;
      data_r <= '0;
      zero_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (flush_i) begin
      state <= ST_IDLE;
    end else if (accept) begin
      zero_r <= (data1_i == data2_i);
      if (is_iter_op(op_in)) begin
        state <= (op_in == ALU_MUL) ? ST_MUL_RUN : ST_DIV_RUN;
        ovf_r <= 1'b0;
      end else begin
        state  <= ST_DONE;
        data_r <= single_res;
        ovf_r  <= single_ovf;
      end
    end else begin
      case (state)
        ST_DONE: if (out_ready_i) state <= ST_IDLE;
        ST_MUL_RUN, ST_DIV_RUN: begin
          if (core_done) begin
            state  <= ST_DONE;
            data_r <= core_result;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// tb/tb_alu_iterative.sv - scoreboard bench for alu_iterative with randomized ops and directed corners
module tb_alu_iterative;
  import alu_pkg::*;

  localparam int W = 32;
  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  typedef struct {
    logic [W-1:0] d;
    logic         z;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] d1 = '0, d2 = '0;
  logic [2:0]   alu_ctrl = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] data_o;
  logic         zero_o, ovf_o, busy;

  bit   rand_mode = 1'b0;
  bit   ready_force = 1'b1;
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  alu_iterative #(.WIDTH(W), .OPW(3)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .data1_i     (d1),
    .data2_i     (d2),
    .ALUCtrl_i   (alu_ctrl),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .data_o      (data_o),
    .Zero_o      (zero_o),
    .ovf_o       (ovf_o),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    int     ia, ib;
    longint la, lb, r;
    ia = a; ib = b; la = ia; lb = ib;
    e.z = (a == b);
    e.o = 1'b0;
    e.d = '0;
    case (op)
      ALU_AND: e.d = a & b;
      ALU_OR:  e.d = a | b;
      ALU_XOR: e.d = a ^ b;
      ALU_ADD: begin r = la + lb; e.d = r[W-1:0]; e.o = (r > MAXI) || (r < MINI); end
      ALU_SUB: begin r = la - lb; e.d = r[W-1:0]; e.o = (r > MAXI) || (r < MINI); end
      ALU_SLT: e.d = (ia < ib) ? 32'd1 : 32'd0;
      ALU_MUL: begin r = la * lb; e.d = r[W-1:0]; end
      ALU_DIV: begin
        if (ib == 0)                     e.d = '1;
        else if (la == MINI && lb == -1) e.d = a;
        else                             e.d = ia / ib;
      end
      default: e.d = '0;
    endcase
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    int k;
    k = $urandom_range(0, 7);
    case (k)
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return W'(int'($urandom_range(0, 20)) - 10);
      default: return $urandom;
    endcase
  endfunction

  // out_ready only changes just after a rising edge so it is stable at every negedge decision point
  always @(posedge clk) begin
    #2;
    out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h required none", data_o);
      end else begin
        e = sbq.pop_front();
        check("data_o", data_o, e.d);
        check("Zero_o", W'(zero_o), W'(e.z));
        check("ovf_o", W'(ovf_o), W'(e.o));
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit push, output int waits);
    alu_ctrl = op; d1 = a; d2 = b; in_valid = 1'b1;
    waits = 0;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 required 1");
      in_valid = 1'b0;
      return;
    end
    if (push) sbq.push_back(model(op, a, b));
    @(negedge clk);
    in_valid = 1'b0;
    d1 = $urandom; d2 = $urandom; alu_ctrl = 3'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((out_valid || busy || sbq.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, cnt, total;
    logic [W-1:0] held;

    repeat (2) @(negedge clk);
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_busy", W'(busy), 0);
    check("rst_data", data_o, 0);
    check("rst_zero", W'(zero_o), 0);
    check("rst_ovf", W'(ovf_o), 0);
    rst_n = 1'b1;
    #1 check("rst_in_ready", W'(in_ready), 1);
    @(negedge clk);

    send(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 1, w);
    check("add_latency", W'(out_valid), 1);
    send(ALU_SUB, 32'd5, 32'd5, 1, w);
    send(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1, w);

    send(ALU_MUL, -32'sd3, 32'd7, 1, w);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("mul_busy_cycles", W'(cnt), 32);
    check("mul_valid_after_busy", W'(out_valid), 1);
    send(ALU_MUL, 32'h1_0000, 32'h1_0000, 1, w);

    send(ALU_DIV, -32'sd7, 32'd2, 1, w);
    send(ALU_DIV, 32'd9, 32'd0, 1, w);
    send(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, w);
    wait_idle();

    ready_force = 1'b0;
    @(posedge clk);
    @(negedge clk);
    send(ALU_ADD, 32'd3, 32'd4, 1, w);
    held = 32'd7;
    repeat (5) begin
      check("stall_data", data_o, held);
      check("stall_valid", W'(out_valid), 1);
      check("stall_in_ready", W'(in_ready), 0);
      @(negedge clk);
    end
    ready_force = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total = 0;
    for (int i = 0; i < 4; i++) begin
      send(ALU_AND, $urandom, $urandom, 1, w);
      total += w;
    end
    check("and_stream_stalls", W'(total), 0);
    check("and_stream_valid", W'(out_valid), 1);
    wait_idle();

    flush = 1'b1; in_valid = 1'b1; alu_ctrl = ALU_ADD;
    @(negedge clk);
    check("flush_blocks_accept", W'(out_valid), 0);
    flush = 1'b0; in_valid = 1'b0;

    send(ALU_DIV, 32'd100, 32'd7, 0, w);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_valid", W'(out_valid), 0);
    check("flush_busy", W'(busy), 0);
    check("flush_in_ready", W'(in_ready), 1);
    send(ALU_SUB, 32'd10, 32'd3, 1, w);
    check("post_flush_valid", W'(out_valid), 1);
    wait_idle();

    send(ALU_MUL, 32'd123, 32'd456, 0, w);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midmul_rst_valid", W'(out_valid), 0);
    check("midmul_rst_busy", W'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midmul_rst_in_ready", W'(in_ready), 1);
    @(negedge clk);

    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(3'($urandom), pick(), pick(), 1, w);
    end
    rand_mode = 1'b0;
    ready_force = 1'b1;
    cnt = 0;
    while (sbq.size() != 0 && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    check("drain_empty", W'(sbq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
